bp_me_burst_pump_out: RTL and testbench

- Outbound companion to the inbound burst pump. It takes beats from a producer FSM (cache engine, I/O bridge, CCE) and forms a BedRock burst on independent header and data channels.
- One header is emitted per message. Data beats are emitted per message type.
- It generates the beat count, wrap-around addressing, and first/last/done control back to the FSM.
- It sits directly upstream of the network or the inbound burst pump of the receiving agent.

---
 rtl/bp_me_burst_pump_out_pkg.sv | 49 ++++
 rtl/bp_me_burst_pump_out_wraparound.sv | 29 ++
 rtl/bp_me_burst_pump_out.sv | 183 ++++++++++++++++++
 tb/tb_bp_me_burst_pump_out.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_burst_pump_out_pkg.sv
// Shared BedRock types for the outbound burst pump: header payload, message
// type/size encodings and stream-mask geometry.
package bp_me_burst_pump_out_pkg;

  localparam int unsigned paddr_width_gp   = 40;
  localparam int unsigned payload_width_gp = 16;
  localparam int unsigned msg_types_gp     = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0
    ,e_bedrock_mem_wr    = 4'd1
    ,e_bedrock_mem_uc_rd = 4'd2
    ,e_bedrock_mem_uc_wr = 4'd3
    ,e_bedrock_mem_pre   = 4'd4
    ,e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_msg_type_e;

  // log2 of the message size in bytes
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0
    ,e_bedrock_msg_size_2   = 3'd1
    ,e_bedrock_msg_size_4   = 3'd2
    ,e_bedrock_msg_size_8   = 3'd3
    ,e_bedrock_msg_size_16  = 3'd4
    ,e_bedrock_msg_size_32  = 3'd5
    ,e_bedrock_msg_size_64  = 3'd6
    ,e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    bp_bedrock_msg_type_e          msg_type;
    bp_bedrock_msg_size_e          size;
    logic [paddr_width_gp-1:0]     addr;
    logic [payload_width_gp-1:0]   payload;
  } bp_bedrock_header_s;

  localparam int unsigned header_width_gp = $bits(bp_bedrock_header_s);

  typedef struct packed {
    logic               has_data;
    bp_bedrock_header_s header;
  } bp_me_hdr_entry_s;

  typedef enum logic {
    e_ready  = 1'b0
    ,e_stream = 1'b1
  } bp_me_pump_state_e;

endpackage

// File: rtl/bp_me_burst_pump_out_wraparound.sv
// Beat counter that wraps inside a power-of-two window; set_i presents val_i
// combinationally so the first beat of a message sees its critical word.
module bp_me_burst_pump_out_wraparound
  #(parameter int unsigned width_p = 3)
  (input  logic               clk_i
  ,input  logic               reset_i
  ,input  logic               set_i
  ,input  logic               en_i
  ,input  logic [width_p-1:0] val_i
  ,input  logic [width_p-1:0] size_i
  ,output logic [width_p-1:0] full_o
  ,output logic [width_p-1:0] wrap_o
  );

  logic [width_p-1:0] cnt_r;

  assign full_o = set_i ? val_i : cnt_r;
  // bits above the window come from the critical word, bits inside it count
  assign wrap_o = (full_o & size_i) | (val_i & ~size_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (set_i | en_i) begin
      cnt_r <= full_o + width_p'(en_i);
    end
  end

endmodule

// File: rtl/bp_me_burst_pump_out.sv
// Outbound burst pump: turns producer FSM beats into a BedRock header plus a
// data burst, generating wrapped beat addresses and first/last/done handshakes.
module bp_me_burst_pump_out
  import bp_me_burst_pump_out_pkg::*;
  #(parameter int unsigned stream_data_width_p = 64
  ,parameter int unsigned block_width_p = 512
  ,parameter logic [msg_types_gp-1:0] msg_stream_mask_p = '0
  ,parameter logic [msg_types_gp-1:0] fsm_stream_mask_p = msg_stream_mask_p
  )
  (input  logic                           clk_i
  ,input  logic                           reset_i
  ,input  bp_bedrock_header_s             fsm_base_header_i
  ,input  logic                           fsm_has_data_i
  ,input  logic [stream_data_width_p-1:0] fsm_data_i
  ,input  logic                           fsm_v_i
  ,output logic                           fsm_ready_and_o
  ,output logic [paddr_width_gp-1:0]      fsm_addr_o
  ,output logic                           fsm_new_o
  ,output logic                           fsm_last_o
  ,output logic                           fsm_done_o
  ,output bp_bedrock_header_s             msg_header_o
  ,output logic                           msg_has_data_o
  ,output logic                           msg_header_v_o
  ,input  logic                           msg_header_ready_and_i
  ,output logic [stream_data_width_p-1:0] msg_data_o
  ,output logic                           msg_last_o
  ,output logic                           msg_data_v_o
  ,input  logic                           msg_data_ready_and_i
  );

  localparam int unsigned stream_off_lp = $clog2(stream_data_width_p / 8);
  localparam int unsigned block_off_lp  = $clog2(block_width_p / 8);
  localparam int unsigned cnt_width_lp  = block_off_lp - stream_off_lp;
  localparam int unsigned fifo_width_lp = stream_data_width_p + 1;

  bp_me_pump_state_e state_r, state_n;

  logic ready_r;
  logic fsm_v;
  logic fsm_stream, msg_stream, multi, mode_n1, mode_1n;
  logic [cnt_width_lp-1:0] stream_size, first_cnt, end_cnt, cnt, wrap_cnt;
  logic is_first, enq_req, slot_ok, hdr_ok, beat_go;
  logic hdr_load, fifo_enq, fifo_last;

  logic             hdr_v_r;
  bp_me_hdr_entry_s hdr_r;
  logic             hdr_deq;

  logic [fifo_width_lp-1:0] fifo_mem_r [2];
  logic                     fifo_wptr_r, fifo_rptr_r;
  logic [1:0]               fifo_cnt_r;
  logic                     fifo_full, fifo_deq;

  // Holds off beat handshakes until the first clock edge after reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ready_r <= 1'b0;
    else         ready_r <= 1'b1;
  end

  assign fsm_v = fsm_v_i & ready_r;

  assign fsm_stream = fsm_stream_mask_p[4'(fsm_base_header_i.msg_type)];
  assign msg_stream = msg_stream_mask_p[4'(fsm_base_header_i.msg_type)];
  assign mode_n1    = fsm_stream & ~msg_stream;
  assign mode_1n    = msg_stream & ~fsm_stream;

  // stream_size = max(2^size / stream_bytes, 1) - 1, saturated to the block
  always_comb begin
    stream_size = '0;
    for (int unsigned i = 0; i < cnt_width_lp; i++) begin
      if (32'(fsm_base_header_i.size) > stream_off_lp + i) stream_size[i] = 1'b1;
    end
  end

  assign first_cnt = fsm_base_header_i.addr[stream_off_lp +: cnt_width_lp];
  assign end_cnt   = first_cnt + stream_size;
  assign multi     = (fsm_stream | msg_stream) & (stream_size != '0);

  bp_me_burst_pump_out_wraparound
    #(.width_p(cnt_width_lp))
    beat_cnt
    (.clk_i  (clk_i)
    ,.reset_i(reset_i)
    ,.set_i  (state_r == e_ready)
    ,.en_i   (beat_go)
    ,.val_i  (first_cnt)
    ,.size_i (stream_size)
    ,.full_o (cnt)
    ,.wrap_o (wrap_cnt)
    );

  assign fsm_addr_o = {fsm_base_header_i.addr[paddr_width_gp-1:block_off_lp]
                      ,wrap_cnt
                      ,fsm_base_header_i.addr[stream_off_lp-1:0]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready:  if (beat_go & multi) state_n = e_stream;
      e_stream: if (fsm_done_o)      state_n = e_ready;
      default:  state_n = e_ready;
    endcase
  end

  // Beat handshake: a 1:N beat advances internally and is only acked at its end
  always_comb begin
    is_first        = 1'b0;
    enq_req         = 1'b0;
    slot_ok         = 1'b0;
    hdr_ok          = 1'b0;
    beat_go         = 1'b0;
    fsm_new_o       = 1'b0;
    fsm_last_o      = 1'b0;
    fsm_ready_and_o = 1'b0;
    fsm_done_o      = 1'b0;
    hdr_load        = 1'b0;
    fifo_enq        = 1'b0;
    fifo_last       = 1'b0;

    is_first   = (state_r == e_ready);
    enq_req    = fsm_has_data_i & (~mode_n1 | is_first);
    slot_ok    = ~enq_req | ~fifo_full;
    hdr_ok     = ~is_first | ~hdr_v_r | hdr_deq;
    beat_go    = fsm_v & hdr_ok & slot_ok;
    fsm_new_o  = is_first & fsm_v;
    fsm_last_o = fsm_v & (~multi | (cnt == end_cnt));
    fsm_ready_and_o = mode_1n ? (beat_go & fsm_last_o) : (ready_r & hdr_ok & slot_ok);
    fsm_done_o = beat_go & fsm_last_o;
    hdr_load   = beat_go & is_first;
    fifo_enq   = beat_go & enq_req;
    fifo_last  = mode_n1 | fsm_last_o;
  end

  assign hdr_deq = hdr_v_r & msg_header_ready_and_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hdr_v_r <= 1'b0;
      hdr_r   <= '0;
    end else if (hdr_load) begin
      hdr_v_r        <= 1'b1;
      hdr_r.has_data <= fsm_has_data_i;
      hdr_r.header   <= fsm_base_header_i;
    end else if (hdr_deq) begin
      hdr_v_r <= 1'b0;
    end
  end

  assign msg_header_v_o = hdr_v_r;
  assign msg_header_o   = hdr_r.header;
  assign msg_has_data_o = hdr_r.has_data;

  // Two-entry data FIFO of {last, data}
  assign fifo_full = (fifo_cnt_r == 2'd2);
  assign fifo_deq  = (fifo_cnt_r != 2'd0) & msg_data_ready_and_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fifo_mem_r[0] <= '0;
      fifo_mem_r[1] <= '0;
      fifo_wptr_r   <= 1'b0;
      fifo_rptr_r   <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      if (fifo_enq) begin
        fifo_mem_r[fifo_wptr_r] <= {fifo_last, fsm_data_i};
        fifo_wptr_r             <= ~fifo_wptr_r;
      end
      if (fifo_deq) fifo_rptr_r <= ~fifo_rptr_r;
      fifo_cnt_r <= fifo_cnt_r + 2'(fifo_enq) - 2'(fifo_deq);
    end
  end

  assign msg_data_v_o = (fifo_cnt_r != 2'd0);
  assign msg_data_o   = fifo_mem_r[fifo_rptr_r][stream_data_width_p-1:0];
  assign msg_last_o   = fifo_mem_r[fifo_rptr_r][stream_data_width_p];

endmodule

// File: tb/tb_bp_me_burst_pump_out.sv
// Randomized bench for the outbound burst pump, checked against a message-level
// model of headers, data beats and beat addresses.
module tb_bp_me_burst_pump_out;
  import bp_me_burst_pump_out_pkg::*;

  localparam logic [15:0] msg_mask_lp = 16'h000A; // wr 1:1, uc_wr 1:N
  localparam logic [15:0] fsm_mask_lp = 16'h0006; // wr 1:1, uc_rd N:1

  logic clk_i = 1'b0;
  logic reset_i;
  bp_bedrock_header_s fsm_base_header_i;
  logic        fsm_has_data_i, fsm_v_i, fsm_ready_and_o;
  logic [63:0] fsm_data_i;
  logic [39:0] fsm_addr_o;
  logic        fsm_new_o, fsm_last_o, fsm_done_o;
  bp_bedrock_header_s msg_header_o;
  logic        msg_has_data_o, msg_header_v_o, msg_header_ready_and_i;
  logic [63:0] msg_data_o;
  logic        msg_last_o, msg_data_v_o, msg_data_ready_and_i;

  always #5 clk_i = ~clk_i;

  bp_me_burst_pump_out
    #(.stream_data_width_p(64), .block_width_p(512)
     ,.msg_stream_mask_p(msg_mask_lp), .fsm_stream_mask_p(fsm_mask_lp))
    dut
    (.clk_i(clk_i), .reset_i(reset_i)
    ,.fsm_base_header_i(fsm_base_header_i), .fsm_has_data_i(fsm_has_data_i)
    ,.fsm_data_i(fsm_data_i), .fsm_v_i(fsm_v_i), .fsm_ready_and_o(fsm_ready_and_o)
    ,.fsm_addr_o(fsm_addr_o), .fsm_new_o(fsm_new_o), .fsm_last_o(fsm_last_o)
    ,.fsm_done_o(fsm_done_o), .msg_header_o(msg_header_o), .msg_has_data_o(msg_has_data_o)
    ,.msg_header_v_o(msg_header_v_o), .msg_header_ready_and_i(msg_header_ready_and_i)
    ,.msg_data_o(msg_data_o), .msg_last_o(msg_last_o), .msg_data_v_o(msg_data_v_o)
    ,.msg_data_ready_and_i(msg_data_ready_and_i));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int last_stall = 0;
  int hdr_mode = 0;  // 0 always ready, 1 random, 2 held low
  int data_mode = 0;
  logic [63:0] hdr_q [$];
  logic [64:0] data_q [$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte address of beat k: wraps inside the size-aligned window of the message
  function automatic logic [39:0] beat_addr(input logic [39:0] a, input logic [2:0] sz, input int k);
    longint unsigned bytes, base, off;
    bytes = 64'd1 << sz;
    if (bytes <= 64'd8) return a;
    base = 64'(a) & ~(bytes - 64'd1);
    off  = (64'(a) - base + 64'(k) * 64'd8) % bytes;
    return 40'(base + off);
  endfunction

  always @(posedge clk_i) begin
    #1;
    msg_header_ready_and_i = (hdr_mode == 0) || (hdr_mode == 1 && $urandom_range(0, 3) != 0);
    msg_data_ready_and_i   = (data_mode == 0) || (data_mode == 1 && $urandom_range(0, 3) != 0);
  end

  // Consumer-side scoreboard
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (msg_header_v_o && msg_header_ready_and_i) begin
        if (hdr_q.size() == 0) check_eq("hdr_unexpected", 1, 0);
        else check_eq("hdr", {msg_has_data_o, msg_header_o}, hdr_q.pop_front());
      end
      if (msg_data_v_o && msg_data_ready_and_i) begin
        if (data_q.size() == 0) check_eq("data_unexpected", 1, 0);
        else check_eq("data", {msg_last_o, msg_data_o}, data_q.pop_front());
      end
      if (fsm_done_o) done_cnt++;
    end
  end

  task automatic send_msg(input bp_bedrock_msg_type_e t, input logic [2:0] sz,
                          input logic [39:0] addr, input logic hd,
                          input logic [63:0] d0, input int stop_after);
    int ss, nf, nd, stall, kk;
    logic fs, ms, one_n;
    logic [63:0] fd [$];
    bp_bedrock_header_s h;
    ss = ((1 << sz) / 8 > 1) ? (1 << sz) / 8 - 1 : 0;
    fs = fsm_mask_lp[t];
    ms = msg_mask_lp[t];
    one_n = ms && !fs && ss > 0;
    nf = (fs && ss > 0) ? ss + 1 : 1;
    nd = hd ? ((ms && ss > 0) ? ss + 1 : 1) : 0;
    for (int k = 0; k < nf; k++) fd.push_back(k == 0 ? d0 : {$urandom, $urandom});
    h.msg_type = t;
    h.size     = bp_bedrock_msg_size_e'(sz);
    h.addr     = addr;
    h.payload  = 16'($urandom);
    hdr_q.push_back({hd, h});
    for (int j = 0; j < nd; j++) data_q.push_back({(j == nd - 1), (fs && ms) ? fd[j] : fd[0]});
    for (int k = 0; k < nf && k < stop_after; k++) begin
      fsm_base_header_i = h;
      fsm_has_data_i    = hd;
      fsm_data_i        = fd[k];
      fsm_v_i           = 1'b1;
      stall = 0;
      forever begin
        @(negedge clk_i);
        if (fsm_ready_and_o) break;
        stall++;
        if (stall > 200) begin
          check_eq("ready_timeout", 0, 1);
          fsm_v_i = 1'b0;
          return;
        end
        @(posedge clk_i); #1;
      end
      kk = one_n ? ss : k;
      check_eq("fsm_addr", fsm_addr_o, beat_addr(addr, sz, kk));
      check_eq("fsm_new", fsm_new_o, (k == 0 && !one_n));
      check_eq("fsm_last", fsm_last_o, (k == nf - 1));
      check_eq("fsm_done", fsm_done_o, (k == nf - 1));
      last_stall = stall;
      @(posedge clk_i); #1;
      if (k == nf - 1) exp_done++;
    end
    fsm_v_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((hdr_q.size() != 0 || data_q.size() != 0) && n < 500) begin
      @(posedge clk_i);
      n++;
    end
    check_eq("drain", 32'(hdr_q.size() + data_q.size()), 0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_hdr_v"}, msg_header_v_o, 0);
    check_eq({tag, "_data_v"}, msg_data_v_o, 0);
    check_eq({tag, "_ready"}, fsm_ready_and_o, 0);
    check_eq({tag, "_new"}, fsm_new_o, 0);
    check_eq({tag, "_last"}, fsm_last_o, 0);
    check_eq({tag, "_done"}, fsm_done_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    fsm_base_header_i = '0;
    fsm_base_header_i.msg_type = e_bedrock_mem_wr;
    fsm_base_header_i.size     = e_bedrock_msg_size_64;
    fsm_has_data_i = 1'b1;
    fsm_data_i = '0;
    fsm_v_i = 1'b1;
    msg_header_ready_and_i = 1'b1;
    msg_data_ready_and_i = 1'b1;
    reset_i = 1'b1;
    #1 check_quiet("in_reset");
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    check_quiet("post_reset");
    fsm_v_i = 1'b0;
    @(posedge clk_i); #1;

    // 64B write at 0x1030: words 6,7,0..5
    send_msg(e_bedrock_mem_wr, 3'd6, 40'h1030, 1'b1, 64'h1111_2222_3333_4444, 99);
    drain();

    // 8B read without data
    send_msg(e_bedrock_mem_rd, 3'd3, 40'h2008, 1'b0, 64'h0, 99);
    drain();

    // Header consumer stalled with a second message pending
    hdr_mode = 2;
    @(posedge clk_i); #1;
    send_msg(e_bedrock_mem_rd, 3'd3, 40'h4000, 1'b0, 64'h0, 99);
    fork
      send_msg(e_bedrock_mem_wr, 3'd3, 40'h4100, 1'b1, 64'hABCD, 99);
      begin
        repeat (5) begin
          @(negedge clk_i);
          check_eq("stall_ready", fsm_ready_and_o, 0);
          check_eq("stall_new", fsm_new_o, 1);
        end
        hdr_mode = 0;
      end
    join
    drain();

    // 1:N: one held beat, eight copies out, ack in the eighth cycle
    send_msg(e_bedrock_mem_uc_wr, 3'd6, 40'h5018, 1'b1, 64'hDEAD, 99);
    check_eq("1n_ack_cycle", last_stall, 7);
    drain();

    // N:1: eight FSM beats, one data beat
    send_msg(e_bedrock_mem_uc_rd, 3'd6, 40'h6000, 1'b1, 64'hBEEF, 99);
    drain();

    // Reset after beat 3 of 8 drops the partial burst
    send_msg(e_bedrock_mem_wr, 3'd6, 40'h7000, 1'b1, 64'h77, 3);
    fsm_v_i = 1'b1;
    reset_i = 1'b1;
    hdr_q.delete();
    data_q.delete();
    #1 check_quiet("mid_reset");
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    check_quiet("mid_post_reset");
    fsm_v_i = 1'b0;
    @(posedge clk_i); #1;
    send_msg(e_bedrock_mem_wr, 3'd6, 40'h7010, 1'b1, 64'h88, 99);
    drain();

    // Random traffic with random consumer back-pressure
    hdr_mode = 1;
    data_mode = 1;
    for (int m = 0; m < 40; m++) begin
      send_msg(bp_bedrock_msg_type_e'(4'($urandom_range(0, 3))), 3'($urandom_range(0, 6)),
               40'({$urandom, $urandom}), 1'($urandom_range(0, 1)), {$urandom, $urandom}, 99);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    drain();
    hdr_mode = 0;
    data_mode = 0;
    repeat (2) @(posedge clk_i);
    check_eq("done_count", done_cnt, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
